// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: command-driven initiator for a single-port register file.
// Accepts read / write / block-copy commands over a valid/ready handshake,
// sequences the register file's we/addr/din/dout port, and returns exactly
// one response per command. The register file loads dout one edge after an
// address is presented with we low, so every read spends a settling cycle
// before the data is captured.
module reg_access_ctrl #(
  parameter int BIT = 8,
  parameter int SZB = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [SZB-1:0] cmd_addr,
  input  logic [SZB-1:0] cmd_addr2,
  input  logic [SZB-1:0] cmd_len,
  input  logic [BIT-1:0] cmd_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [BIT-1:0] rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic           rf_we,
  output logic [SZB-1:0] rf_addr,
  output logic [BIT-1:0] rf_din,
  input  logic [BIT-1:0] rf_dout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR,
    CP_RD,
    CP_WAIT,
    CP_WR,
    RSP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t         state;
  logic [SZB-1:0] src;
  logic [SZB-1:0] dst;
  logic [SZB-1:0] len;
  // Words already copied; one bit wider than the address so it can hold a
  // full 2**SZB-word count without aliasing.
  logic [SZB:0]   count;
  logic [SZB:0]   count_inc;
  logic [SZB-1:0] src_inc;
  logic [SZB-1:0] dst_inc;

  // Next-word values; address increments wrap naturally at 2**SZB.
  assign count_inc = count + 1'b1;
  assign src_inc   = src + 1'b1;
  assign dst_inc   = dst + 1'b1;

  // Single FSM: every output is a register updated on the state transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_din    <= '0;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              OP_READ: begin
                rf_addr <= cmd_addr;
                state   <= RD_WAIT;
              end
              OP_WRITE: begin
                rf_we   <= 1'b1;
                rf_addr <= cmd_addr;
                rf_din  <= cmd_data;
                state   <= WR;
              end
              OP_COPY: begin
                src   <= cmd_addr;
                dst   <= cmd_addr2;
                len   <= cmd_len;
                count <= '0;
                if (cmd_len == '0) begin
                  // Zero-length copy: answer immediately, touch nothing.
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b0;
                  state     <= RSP;
                end else begin
                  rf_addr <= cmd_addr;
                  state   <= CP_RD;
                end
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                state     <= RSP;
              end
            endcase
          end
        end
        // Register file latches dout from rf_addr on this edge.
        RD_WAIT: state <= RD_CAP;
        RD_CAP: begin
          rsp_data  <= rf_dout;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        // The write happens on this edge; rf_din still holds the command data.
        WR: begin
          rf_we     <= 1'b0;
          rsp_data  <= rf_din;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        CP_RD: state <= CP_WAIT;
        CP_WAIT: begin
          rf_we   <= 1'b1;
          rf_addr <= dst;
          rf_din  <= rf_dout;
          state   <= CP_WR;
        end
        CP_WR: begin
          rf_we <= 1'b0;
          src   <= src_inc;
          dst   <= dst_inc;
          count <= count_inc;
          if (count_inc == {1'b0, len}) begin
            rsp_data  <= {{(BIT-SZB){1'b0}}, len};
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            rf_addr <= src_inc;
            state   <= CP_RD;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: scoreboard bench for reg_access_ctrl with a behavioural
// register file attached. The stimulus side runs commands against a plain
// array model and queues the expected responses and register-file writes;
// independent monitors pop and compare whenever the DUT shows a response
// handshake or an rf_we cycle.
module tb_reg_access_ctrl;
  localparam int BIT   = 8;
  localparam int SZB   = 4;
  localparam int DEPTH = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [SZB-1:0] cmd_addr;
  logic [SZB-1:0] cmd_addr2;
  logic [SZB-1:0] cmd_len;
  logic [BIT-1:0] cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [BIT-1:0] rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           rf_we;
  logic [SZB-1:0] rf_addr;
  logic [BIT-1:0] rf_din;
  logic [BIT-1:0] rf_dout = '0;

  // Register file: dout follows addr one edge later while we is low, holds while we is high.
  logic [BIT-1:0] rf_mem [DEPTH] = '{default: 8'h00};
  always @(posedge clock) begin
    if (rf_we) rf_mem[rf_addr] <= rf_din;
    else       rf_dout <= rf_mem[rf_addr];
  end

  reg_access_ctrl #(.BIT(BIT), .SZB(SZB)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_addr2(cmd_addr2), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic hold_low = 1'b0;

  logic [BIT-1:0]     ref_mem [DEPTH];
  logic [BIT:0]       rsp_q [$];   // {err, data}
  logic [SZB+BIT-1:0] wr_q  [$];   // {addr, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: plain array semantics, copy done word by word ascending.
  task automatic model(input logic [1:0] op, input logic [SZB-1:0] a, input logic [SZB-1:0] a2,
                       input logic [SZB-1:0] l, input logic [BIT-1:0] d,
                       output logic [BIT-1:0] rd, output int lat);
    logic e;
    e = 1'b0;
    rd = '0;
    lat = 1;
    case (op)
      2'd0: begin
        rd = ref_mem[a];
        lat = 3;
      end
      2'd1: begin
        ref_mem[a] = d;
        wr_q.push_back({a, d});
        rd = d;
        lat = 2;
      end
      2'd2: begin
        for (int i = 0; i < int'(l); i++) begin
          int s;
          int t;
          s = (int'(a) + i) % DEPTH;
          t = (int'(a2) + i) % DEPTH;
          ref_mem[t] = ref_mem[s];
          wr_q.push_back({4'(t), ref_mem[t]});
        end
        rd = 8'(l);
        lat = (l == '0) ? 1 : 3 * int'(l) + 1;
      end
      default: e = 1'b1;
    endcase
    rsp_q.push_back({e, rd});
  endtask

  // Present one command, wait for acceptance and for rsp_valid to rise.
  task automatic issue(input logic [1:0] op, input logic [SZB-1:0] a, input logic [SZB-1:0] a2,
                       input logic [SZB-1:0] l, input logic [BIT-1:0] d, output logic [BIT-1:0] rd);
    int lat_exp;
    int lat;
    int n;
    model(op, a, a2, l, d, rd, lat_exp);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_addr2 = a2; cmd_len = l; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("accept", 32'(cmd_ready), 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("ready_after_accept", 32'(cmd_ready), 0);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check($sformatf("latency_op%0d", op), lat, lat_exp);
  endtask

  task automatic finish_rsp();
    int n;
    n = 0;
    while (rsp_valid && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("rsp_drained", 32'(rsp_valid), 0);
    check("idle_ready", 32'(cmd_ready), 1);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [SZB-1:0] a, input logic [SZB-1:0] a2,
                        input logic [SZB-1:0] l, input logic [BIT-1:0] d);
    logic [BIT-1:0] rd;
    issue(op, a, a2, l, d, rd);
    finish_rsp();
  endtask

  // Requester side: randomly throttled rsp_ready, changed away from both clock edges.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: pop expectations on every response handshake and every rf_we cycle.
  initial begin
    logic [BIT:0]       er;
    logic [SZB+BIT-1:0] ew;
    forever begin
      @(negedge clock);
      if (!reset && rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
        end else begin
          er = rsp_q.pop_front();
          $display("rsp  data=%02h err=%0d (expected %02h/%0d)", rsp_data, rsp_err, er[BIT-1:0], er[BIT]);
          check("rsp_data", 32'(rsp_data), 32'(er[BIT-1:0]));
          check("rsp_err", 32'(rsp_err), 32'(er[BIT]));
        end
      end
      if (!reset && rf_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_rf_we", 32'({rf_addr, rf_din}), 32'hFFFF_FFFF);
        end else begin
          ew = wr_q.pop_front();
          check("rf_we_addr", 32'(rf_addr), 32'(ew[SZB+BIT-1:BIT]));
          check("rf_we_din", 32'(rf_din), 32'(ew[BIT-1:0]));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rf_we"}, 32'(rf_we), 0);
    check({tag, "_rf_addr"}, 32'(rf_addr), 0);
    check({tag, "_rf_din"}, 32'(rf_din), 0);
  endtask

  initial begin
    logic [BIT-1:0] rd;
    logic [BIT-1:0] expd;
    int n;
    int we_seen;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_addr2 = '0; cmd_len = '0; cmd_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("post_reset");

    // Fresh register file reads back zero.
    do_cmd(2'd0, 4'd7, 4'd0, 4'd0, 8'h00);
    // Write then read back.
    do_cmd(2'd1, 4'd3, 4'd0, 4'd0, 8'hA5);
    do_cmd(2'd0, 4'd3, 4'd0, 4'd0, 8'h00);
    // Copy whose source wraps past the top address.
    do_cmd(2'd1, 4'd14, 4'd0, 4'd0, 8'h11);
    do_cmd(2'd1, 4'd15, 4'd0, 4'd0, 8'h22);
    do_cmd(2'd1, 4'd0,  4'd0, 4'd0, 8'h33);
    do_cmd(2'd2, 4'd14, 4'd1, 4'd3, 8'h00);
    for (int i = 1; i <= 3; i++) do_cmd(2'd0, 4'(i), 4'd0, 4'd0, 8'h00);
    // Illegal opcode and zero-length copy.
    do_cmd(2'd3, 4'd5, 4'd6, 4'd7, 8'h99);
    do_cmd(2'd2, 4'd2, 4'd9, 4'd0, 8'h00);

    // Response back-pressure with a stray command that must be ignored.
    hold_low = 1'b1;
    issue(2'd0, 4'd3, 4'd0, 4'd0, 8'h00, rd);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", 32'(rsp_data), 32'(rd));
      check("hold_cmd_ready", 32'(cmd_ready), 0);
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd3; cmd_data = 8'hFF;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    hold_low = 1'b0;
    finish_rsp();
    do_cmd(2'd0, 4'd3, 4'd0, 4'd0, 8'h00);

    // Randomized traffic against the array model, including overlapping copies.
    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      n = $urandom_range(0, 9);
      op = (n < 3) ? 2'd0 : (n < 6) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
      do_cmd(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 6)), 8'($urandom_range(0, 255)));
    end

    // Reset during the write of word 2 of a 4-word copy: only word 1 lands.
    expd = ref_mem[5];
    ref_mem[9] = expd;
    wr_q.push_back({4'd9, expd});
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 4'd5; cmd_addr2 = 4'd9; cmd_len = 4'd4;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    we_seen = 0;
    n = 0;
    while (we_seen < 2 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (rf_we) we_seen++;
    end
    check("mid_copy_second_we", we_seen, 2);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("after_abort_ready", 32'(cmd_ready), 1);
      check("after_abort_no_rsp", 32'(rsp_valid), 0);
    end
    do_cmd(2'd0, 4'd9, 4'd0, 4'd0, 8'h00);
    do_cmd(2'd0, 4'd10, 4'd0, 4'd0, 8'h00);

    repeat (4) @(negedge clock);
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
